// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   size_e  : access-size encodings carried on i_memSize
//   state_e : responder FSM states
//   CNT_W   : width of the latency down-counter (LATENCY up to 15)
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store datapath and dmem_responder.
//   i_memReq   : access request, held by the requester until accepted
//   i_memWrite : 1 = store, 0 = load
//   i_memSize  : 00 byte, 01 half, 10 word, 11 illegal
//   i_addr     : byte address
//   i_wdata    : right-justified store data
//   o_ready    : responder can accept a request this cycle
//   o_rvalid   : one-cycle response strobe
//   o_rdata    : aligned word read (0 for stores and errors)
//   o_err      : misaligned / illegal-size flag, valid with o_rvalid
// Modports: master = requester side, slave = responder side.
interface dmem_responder_if;
    logic        i_memReq;
    logic        i_memWrite;
    logic [1:0]  i_memSize;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic        o_rvalid;
    logic [31:0] o_rdata;
    logic        o_err;

    modport master (
        output i_memReq, i_memWrite, i_memSize, i_addr, i_wdata,
        input  o_ready, o_rvalid, o_rdata, o_err
    );

    modport slave (
        input  i_memReq, i_memWrite, i_memSize, i_addr, i_wdata,
        output o_ready, o_rvalid, o_rdata, o_err
    );
endinterface

// File: rtl/byte_lane_ctrl.sv
// Combinational byte-lane steering for stores.
//   size      : access size (size_e encoding)
//   addr_lo   : byte offset within the word
//   wdata     : right-justified store data
//   byte_en   : per-byte write enable (all zero when misaligned)
//   wdata_rep : store data replicated across the lanes
//   misalign  : misaligned access or illegal size
module byte_lane_ctrl
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic        misalign
);

    always_comb begin
        byte_en   = '0;
        wdata_rep = '0;
        misalign  = 1'b0;
        case (size_e'(size))
            SIZE_B: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                wdata_rep = {2{wdata[15:0]}};
                if (addr_lo[0]) begin
                    misalign = 1'b1;
                end else begin
                    byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
            end
            SIZE_W: begin
                wdata_rep = wdata;
                if (addr_lo != 2'b00) begin
                    misalign = 1'b1;
                end else begin
                    byte_en = 4'b1111;
                end
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency single-port data memory responder.
// A request accepted on edge k is performed on edge k+LATENCY and answered
// with a one-cycle o_rvalid strobe in the following cycle.
//   clk     : clock, rising edge only
//   reset_x : asynchronous active-low reset (storage is not cleared)
//   bus     : dmem_responder_if slave modport (request in, response out)
// Parameters:
//   DEPTH_WORDS : number of 32-bit words, power of two (>= 2)
//   LATENCY     : edges from acceptance to access, 1..15
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic             clk,
    input  logic             reset_x,
    dmem_responder_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_e             state;
    state_e             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               accept;
    logic               do_access;

    logic               req_write;
    logic [1:0]         req_size;
    logic [31:0]        req_addr;
    logic [31:0]        req_wdata;

    logic [3:0]         byte_en;
    logic [31:0]        wdata_rep;
    logic               misalign;

    logic [AW-1:0]      word_idx;
    logic [31:0]        mem [DEPTH_WORDS];
    logic [31:0]        mem_rd;

    logic               rvalid_q;
    logic               err_q;
    logic [31:0]        rdata_q;

    // Upper address bits do not select storage; addresses wrap.
    logic               unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW+2];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        do_access = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.i_memReq) begin
                    accept    = 1'b1;
                    state_nxt = ST_BUSY;
                    cnt_nxt   = CNT_W'(LATENCY - 1);
                end
            end
            ST_BUSY: begin
                if (cnt == '0) begin
                    do_access = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.o_ready = (state == ST_IDLE);

    // ---------------- request latch ----------------
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            req_write <= 1'b0;
            req_size  <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else if (accept) begin
            req_write <= bus.i_memWrite;
            req_size  <= bus.i_memSize;
            req_addr  <= bus.i_addr;
            req_wdata <= bus.i_wdata;
        end
    end

    byte_lane_ctrl u_lane (
        .size      (req_size),
        .addr_lo   (req_addr[1:0]),
        .wdata     (req_wdata),
        .byte_en   (byte_en),
        .wdata_rep (wdata_rep),
        .misalign  (misalign)
    );

    // ---------------- storage ----------------
    assign word_idx = req_addr[AW+1:2];
    assign mem_rd   = mem[word_idx];

    // No reset: contents survive reset. An abandoned access never reaches
    // do_access because reset forces the FSM to IDLE asynchronously.
    always_ff @(posedge clk) begin
        if (do_access && req_write) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    // ---------------- response ----------------
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= do_access;
            err_q    <= do_access && misalign;
            if (do_access) begin
                rdata_q <= (req_write || misalign) ? '0 : mem_rd;
            end
        end
    end

    assign bus.o_rvalid = rvalid_q;
    assign bus.o_err    = err_q;
    assign bus.o_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with LATENCY=1 and one
// with LATENCY=3, each with its own bus interface and reset.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1;
    logic rst3;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    resp_t       q1[$];
    resp_t       q3[$];
    bit [31:0]   m1[int];
    bit [31:0]   m3[int];
    logic [31:0] last1;
    logic [31:0] last3;

    dmem_responder_if if1();
    dmem_responder_if if3();

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .reset_x(rst1), .bus(if1)
    );
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) dut3 (
        .clk(clk), .reset_x(rst3), .bus(if3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat(input int w);
        return (w == 1) ? 1 : 3;
    endfunction

    function automatic logic rdy(input int w);
        return (w == 1) ? if1.o_ready : if3.o_ready;
    endfunction

    task automatic drive(input int w, input bit req, input bit wr, input bit [1:0] sz,
                         input bit [31:0] a, input bit [31:0] d);
        if (w == 1) begin
            if1.i_memReq = req; if1.i_memWrite = wr; if1.i_memSize = sz;
            if1.i_addr = a;     if1.i_wdata = d;
        end else begin
            if3.i_memReq = req; if3.i_memWrite = wr; if3.i_memSize = sz;
            if3.i_addr = a;     if3.i_wdata = d;
        end
    endtask

    // Reference behaviour: computes the response and updates the model memory.
    function automatic resp_t model(input int w, input bit wr, input bit [1:0] sz,
                                    input bit [31:0] a, input bit [31:0] d, input int exp_cyc);
        resp_t     r;
        int        idx;
        bit        mis;
        bit [31:0] cur;
        idx = int'((a >> 2) & 32'd1023);
        mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        if (w == 1) cur = m1.exists(idx) ? m1[idx] : 32'h0;
        else        cur = m3.exists(idx) ? m3[idx] : 32'h0;
        r.cyc = exp_cyc;
        r.err = mis;
        r.rdata = 32'h0;
        if (!mis) begin
            if (wr) begin
                case (sz)
                    2'b00:   cur[8*a[1:0] +: 8] = d[7:0];
                    2'b01:   cur[16*a[1] +: 16] = d[15:0];
                    default: cur = d;
                endcase
                if (w == 1) m1[idx] = cur; else m3[idx] = cur;
            end else begin
                r.rdata = cur;
            end
        end
        return r;
    endfunction

    task automatic issue(input int w, input bit wr, input bit [1:0] sz, input bit [31:0] a,
                         input bit [31:0] d, input bit push, output int acc, output int waited);
        resp_t r;
        waited = 0;
        acc = -1;
        @(negedge clk);
        drive(w, 1'b1, wr, sz, a, d);
        while (!rdy(w)) begin
            if (waited >= 40) begin
                check("accept_timeout", 32'd0, 32'd1);
                drive(w, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
                return;
            end
            @(negedge clk);
            waited++;
        end
        acc = cyc;
        if (push) begin
            r = model(w, wr, sz, a, d, cyc + 1 + lat(w));
            if (w == 1) q1.push_back(r); else q3.push_back(r);
        end
        @(posedge clk);
        #1 drive(w, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic op(input int w, input bit wr, input bit [1:0] sz, input bit [31:0] a,
                      input bit [31:0] d);
        int acc, waited;
        issue(w, wr, sz, a, d, 1'b1, acc, waited);
    endtask

    // Response monitors
    always @(negedge clk) begin
        resp_t r;
        if (!rst1) begin
            last1 = '0;
        end else if (if1.o_rvalid) begin
            if (q1.size() == 0) begin
                check("d1_spurious_rvalid", 32'd1, 32'd0);
            end else begin
                r = q1.pop_front();
                check("d1_rdata", if1.o_rdata, r.rdata);
                check("d1_err", {31'd0, if1.o_err}, {31'd0, r.err});
                check("d1_latency", cyc, r.cyc);
                last1 = r.rdata;
            end
        end else begin
            check("d1_err_idle", {31'd0, if1.o_err}, 32'd0);
            check("d1_rdata_hold", if1.o_rdata, last1);
        end
    end

    always @(negedge clk) begin
        resp_t r;
        if (!rst3) begin
            last3 = '0;
        end else if (if3.o_rvalid) begin
            if (q3.size() == 0) begin
                check("d3_spurious_rvalid", 32'd1, 32'd0);
            end else begin
                r = q3.pop_front();
                check("d3_rdata", if3.o_rdata, r.rdata);
                check("d3_err", {31'd0, if3.o_err}, {31'd0, r.err});
                check("d3_latency", cyc, r.cyc);
                last3 = r.rdata;
            end
        end else begin
            check("d3_err_idle", {31'd0, if3.o_err}, 32'd0);
            check("d3_rdata_hold", if3.o_rdata, last3);
        end
    end

    initial begin
        int a1, a2, w1, w2;
        bit [31:0] ra;

        rst1 = 1'b0;
        rst3 = 1'b0;
        drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(3, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("rst_ready1",  {31'd0, if1.o_ready},  32'd1);
        check("rst_rvalid1", {31'd0, if1.o_rvalid}, 32'd0);
        check("rst_rdata1",  if1.o_rdata, 32'd0);
        check("rst_err1",    {31'd0, if1.o_err},    32'd0);
        check("rst_ready3",  {31'd0, if3.o_ready},  32'd1);
        check("rst_rvalid3", {31'd0, if3.o_rvalid}, 32'd0);
        rst1 = 1'b1;
        rst3 = 1'b1;

        // Word store/load and byte/half merging
        op(1, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
        op(1, 1'b0, 2'b10, 32'h10, 32'h0);
        op(1, 1'b1, 2'b00, 32'h11, 32'h00000055);
        op(1, 1'b1, 2'b01, 32'h12, 32'h0000A5A5);
        op(1, 1'b0, 2'b10, 32'h10, 32'h0);

        // Misalignment and illegal size
        op(1, 1'b1, 2'b10, 32'h20, 32'h12345678);
        op(1, 1'b0, 2'b10, 32'h22, 32'h0);
        op(1, 1'b1, 2'b01, 32'h21, 32'h0000FFFF);
        op(1, 1'b0, 2'b10, 32'h20, 32'h0);
        op(1, 1'b0, 2'b11, 32'h20, 32'h0);
        op(1, 1'b1, 2'b11, 32'h20, 32'hFFFFFFFF);
        op(1, 1'b0, 2'b10, 32'h20, 32'h0);

        // Address wrap-around
        op(1, 1'b1, 2'b10, 32'h1000, 32'h0BADF00D);
        op(1, 1'b0, 2'b10, 32'h0, 32'h0);

        // Randomised traffic over a preloaded window, high bits aliased
        for (int i = 0; i < 16; i++) op(1, 1'b1, 2'b10, 32'h80 + 32'(4*i), $urandom);
        for (int i = 0; i < 40; i++) begin
            ra = 32'h80 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << 12);
            op(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom);
        end

        // LATENCY=3: busy window and acceptance in the rvalid cycle
        op(3, 1'b1, 2'b10, 32'h40, 32'h0);
        issue(3, 1'b1, 2'b10, 32'h44, 32'h11112222, 1'b1, a1, w1);
        issue(3, 1'b0, 2'b10, 32'h44, 32'h0, 1'b1, a2, w2);
        check("d3_busy_cycles", w2, 3);
        check("d3_accept_gap", a2 - a1, 4);

        // Reset while a store is pending
        issue(3, 1'b1, 2'b10, 32'h40, 32'hFFFFFFFF, 1'b0, a1, w1);
        @(posedge clk);
        #1 rst3 = 1'b0;
        #1;
        check("midrst_ready",  {31'd0, if3.o_ready},  32'd1);
        check("midrst_rvalid", {31'd0, if3.o_rvalid}, 32'd0);
        check("midrst_rdata",  if3.o_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst3 = 1'b1;
        repeat (6) @(negedge clk);
        op(3, 1'b0, 2'b10, 32'h40, 32'h0);
        op(3, 1'b0, 2'b10, 32'h44, 32'h0);

        for (int i = 0; i < 50 && (q1.size() != 0 || q3.size() != 0); i++) @(negedge clk);
        check("drain_q1", q1.size(), 32'd0);
        check("drain_q3", q3.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in storage; it SHALL be a power of two.
REQ-002 SHALL have parameter LATENCY, default 1, meaning the edges from acceptance to response; legal range is 1..15.
REQ-003 SHALL have port clk, input, 1, the single clock; the block SHALL use rising edges only.
REQ-004 SHALL have port reset_x, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have port i_memReq, input, 1, the access request.
REQ-006 SHALL have port i_memWrite, input, 1, where 1 = store and 0 = load.
REQ-007 SHALL have port i_memSize, input, 2, the access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 SHALL have port i_addr, input, 32, the byte address.
REQ-009 SHALL have port i_wdata, input, 32, the store data, right-justified.
REQ-010 SHALL have port o_ready, output, 1, meaning the block can accept a request this cycle.
REQ-011 SHALL have port o_rvalid, output, 1, a one-cycle response strobe.
REQ-012 SHALL have port o_rdata, output, 32, the aligned word read.
REQ-013 SHALL have port o_err, output, 1, a misaligned or illegal-size flag, valid with o_rvalid.

Function
REQ-014 SHALL accept a request on an edge where i_memReq=1 and o_ready=1, latching memWrite, memSize, addr and wdata.
REQ-015 SHALL ignore i_memReq while o_ready=0; the requester holds its request until accepted.
REQ-016 FSM states SHALL be IDLE and BUSY, with these transitions:
- IDLE -> BUSY on acceptance, loading the counter with LATENCY-1.
- BUSY decrements the counter each edge.
- BUSY -> IDLE on the edge where the counter equals 0.
REQ-017 o_ready SHALL be 1 exactly when the state is IDLE.
REQ-018 For a request accepted on edge k, the access SHALL take place on edge k+LATENCY.
REQ-019 For that request, o_rvalid SHALL be 1 for exactly the cycle after edge k+LATENCY.
REQ-020 A new request MAY be accepted in the o_rvalid cycle, giving a throughput of one access per LATENCY+1 cycles.
REQ-021 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap around.
REQ-022 A store SHALL replicate wdata across lanes and write the enabled bytes only:
- byte: enable lane addr[1:0] with wdata[7:0].
- half: enable lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
- word: enable all four lanes with wdata.
REQ-023 A load SHALL return the full aligned word on o_rdata; lane selection and sign/zero extension belong to the datapath.
REQ-024 A store response SHALL drive o_rdata = 0.
REQ-025 An access SHALL be treated as an error if any of the following holds: size half with addr[0]=1, size word with addr[1:0]!=00, or size 11.
REQ-026 An errored access SHALL perform no write, and its response SHALL give o_rdata=0 and o_err=1.
REQ-027 o_err SHALL be 0 whenever o_rvalid=0.
REQ-028 A load accepted after a store's o_rvalid cycle SHALL observe the stored data; there SHALL be no read-after-write bypass hazard.
REQ-029 o_rdata SHALL hold its last value outside o_rvalid cycles.

Reset
REQ-030 reset_x=0 SHALL asynchronously force: state IDLE, counter 0, o_ready=1 (combinational from the state), o_rvalid=0, o_rdata=0, o_err=0, and latched request fields 0.
REQ-031 Reset during BUSY SHALL abandon the pending access: a pending store SHALL NOT be written and no o_rvalid SHALL be issued.
REQ-032 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-033 Shared package dmem_pkg SHALL hold the size encodings (SIZE_B, SIZE_H, SIZE_W) and the FSM state encodings.
REQ-034 One sub-module, byte_lane_ctrl, SHALL be combinational: it takes size, addr[1:0] and wdata, and produces a 4-bit byte enable, the replicated wdata, and the misalignment flag.
REQ-035 Storage SHALL be a single-port word array with per-byte write enable.

Verification
REQ-036 With LATENCY=1, SW 0xDEADBEEF @0x10 then LW @0x10 -> each response rvalid 2 cycles after the req edge; load o_rdata=0xDEADBEEF, o_err=0.
REQ-037 After that word, SB 0x55 @0x11 then SH 0xA5A5 @0x12 then LW @0x10 -> o_rdata=0xA5A555EF.
REQ-038 With word 0x12345678 @0x20: LW @0x22 -> o_err=1, o_rdata=0; SH @0x21 -> o_err=1, word unchanged; size 11 -> o_err=1.
REQ-039 With LATENCY=3, a req held high -> o_ready low for 3 cycles, rvalid in cycle 4, a second req accepted in the rvalid cycle.
REQ-040 Reset asserted 1 cycle after accepting SW 0xFFFFFFFF @0x40 (LATENCY=3), word previously 0x0 -> no rvalid, o_ready=1 after reset, LW @0x40 returns 0x00000000.
REQ-041 With DEPTH_WORDS=1024, SW 0x0BADF00D @0x1000 then LW @0x0 -> o_rdata=0x0BADF00D (wrap-around).
